aes_key_schedule_engine: RTL and testbench
==========================================

// Module: aes_key_schedule_engine
// PURPOSE
//  Iterative FIPS-197 key expansion for AES-128/192/256. Computes one 32-bit word per
//  cycle and streams the Nr+1 128-bit round keys in order over a valid/ready port.
//  Replaces fixed-table expansion. Sits between key load and the cipher round datapath.
// PARAMETERS
//  ENABLE_192  1  0: key_size 2'b01 is illegal (192-bit logic removed)
//  ENABLE_256  1  0: key_size 2'b10 is illegal (256-bit logic removed)
// PORTS
//  clk       in   1    rising-edge clock
//  rst       in   1    reset, asynchronous, active-high
//  start     in   1    1-cycle request; sampled only when busy=0
//  key_size  in   2    00=128 (Nk4,Nr10), 01=192 (Nk6,Nr12), 10=256 (Nk8,Nr14), 11 illegal
//  key       in   256  byte0 at [255:248]; 128 uses [255:128], 192 uses [255:64]
//  rk_valid  out  1    rk_data/rk_index hold a round key
//  rk_ready  in   1    consumer accepts on rk_valid&rk_ready at clk edge
//  rk_data   out  128  round key, w[4r] at [127:96] .. w[4r+3] at [31:0]
//  rk_index  out  4    round number r, 0..Nr
//  busy      out  1    expansion in progress
//  done      out  1    1-cycle pulse: last round key (r=Nr) accepted
//  err       out  1    1-cycle pulse: start with illegal key_size
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, window/rcon/counters cleared; asserts any cycle,
//   aborts an expansion in flight, no done pulse.
//  FSM IDLE->RUN on start & legal size; key, Nk, Nr latched; busy=1 from next cycle.
//   start & illegal: err=1 next cycle, stays IDLE. start while busy: ignored.
//  RUN->IDLE when key r=Nr accepted; done=1 and busy=0 in the cycle after that edge.
//  Word gen, index i=0..4(Nr+1)-1, one word per edge when not stalled:
//   i<Nk: w[i] = latched key word i.
//   i>=Nk: t=w[i-1]; if i mod Nk==0: t=SubWord(RotWord(t))^{rcon,24'h0}, then rcon=xtime(rcon);
//    else if Nk==8 & i mod Nk==4: t=SubWord(t); w[i]=w[i-Nk]^t.
//   rcon starts 8'h01; xtime: {rcon[6:0],1'b0} ^ (rcon[7]?8'h1b:8'h00) (01..80,1b,36).
//   i mod Nk from wrap counter, no divider. Window = 8x32 shift reg; w[i-Nk] at tap Nk-1.
//  Assembly: words i mod 4 = 0..2 go to 3-word buffer; word i mod 4 = 3 completes a key:
//   loaded into rk_data, rk_valid=1, rk_index=i/4. Word i mod 4==3 stalls
//   (no state change) while rk_valid & !rk_ready; other words never stall.
//  Timing: start at edge E0 -> w0..w3 at E1..E4 -> rk_valid after E4. rk_ready held 1:
//   one key per 4 cycles, no bubbles; key Nr valid after E(4Nr+4).
//  rk_valid drops after acceptance unless a new key loads same edge; rk_data/rk_index
//   stable while rk_valid & !rk_ready.
//  rk_index counts 0..Nr, never wraps; after done rk_data keeps last key, rk_valid=0.
//  SubWord: 4 combinational S-box lookups (function/case ROM), no extra latency.
// TESTING
//  1 size 00, key 000102..0f, rk_ready=1 -> r1=d6aa74fdd2af72fadaa678f1d6ab76fe,
//    r10=13111d7fe3944a17f307a78b4d2b30c5 after E44; done next cycle; 11 keys total.
//  2 size 01, key 000102..17 -> 13 keys, r12=a4970a331a78dc09c418c271e3a41d5d;
//    size 10, key 00..1f -> 15 keys, r14=24fc79ccbf0979e9371ac23c6d68de36.
//  3 size 00, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready random 30%
//    -> r10=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_data stable during stalls; no loss/dup.
//  4 key_size 11 start -> err pulse 1 cycle, busy=0, rk_valid=0; ENABLE_256=0 and
//    size 10 -> err pulse; second start while busy -> ignored, sequence unchanged.
//  5 rst asserted mid-run (e.g., r=5 valid) -> all outputs 0 at once, no done;
//    new start -> full correct sequence from r0.

Source files
------------

// File: rtl/aes_key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion: one 32-bit word per clock, streaming the
// Nr+1 round keys in order over a valid/ready port.
module aes_key_schedule_engine #(
    parameter int unsigned ENABLE_192 = 1,
    parameter int unsigned ENABLE_256 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_size,
    input  logic [255:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [255:0] key_sr;
    logic [3:0]   nk, nr;
    logic [5:0]   widx, last_w;
    logic [2:0]   kmod;
    logic [7:0]   rcon;
    logic [31:0]  win  [0:7];
    logic [31:0]  wbuf [0:2];
    logic [31:0]  t_word, w_new;
    logic         legal, start_ok, start_bad, stall, adv, accept, last_acc;

    assign legal    = (key_size == 2'b00) ||
                      (key_size == 2'b01 && ENABLE_192 != 0) ||
                      (key_size == 2'b10 && ENABLE_256 != 0);
    assign last_w   = {nr, 2'b11};
    assign accept   = rk_valid & rk_ready;
    // only the key-completing word waits on the consumer
    assign stall    = (widx[1:0] == 2'b11) & rk_valid & ~rk_ready;
    assign adv      = (state == RUN) & (widx <= last_w) & ~stall;
    assign last_acc = (state == RUN) & accept & (rk_index == nr);
    assign busy     = (state == RUN);

    // win[0] holds w[i-1]; w[i-Nk] sits at tap Nk-1
    always_comb begin
        t_word = win[0];
        if (kmod == 3'd0)
            t_word = sub_word({win[0][23:0], win[0][31:24]}) ^ {rcon, 24'h0};
        else if (nk == 4'd8 && kmod == 3'd4)
            t_word = sub_word(win[0]);
        w_new = (widx < {2'b00, nk}) ? key_sr[255:224] : (win[3'(nk - 4'd1)] ^ t_word);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (legal) begin
                    start_ok  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    start_bad = 1'b1;
                end
            end
            RUN:     if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sr   <= '0;
            nk       <= '0;
            nr       <= '0;
            widx     <= '0;
            kmod     <= '0;
            rcon     <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) wbuf[k] <= '0;
        end else begin
            done <= last_acc;
            err  <= start_bad;
            if (start_ok) begin
                key_sr <= key;
                widx   <= '0;
                kmod   <= '0;
                rcon   <= 8'h01;
                case (key_size)
                    2'b00:   begin nk <= 4'd4; nr <= 4'd10; end
                    2'b01:   begin nk <= 4'd6; nr <= 4'd12; end
                    default: begin nk <= 4'd8; nr <= 4'd14; end
                endcase
            end
            if (accept) rk_valid <= 1'b0;
            if (adv) begin
                key_sr <= {key_sr[223:0], 32'h0};
                for (int k = 7; k > 0; k--) win[k] <= win[k-1];
                win[0] <= w_new;
                widx   <= widx + 6'd1;
                kmod   <= (kmod == 3'(nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
                if (widx >= {2'b00, nk} && kmod == 3'd0) rcon <= xtime(rcon);
                if (widx[1:0] == 2'b11) begin
                    rk_data  <= {wbuf[0], wbuf[1], wbuf[2], w_new};
                    rk_valid <= 1'b1;
                    rk_index <= widx[5:2];
                end else begin
                    wbuf[widx[1:0]] <= w_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Directed bench for aes_key_schedule_engine using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_engine;

    localparam logic [255:0] K128A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [1:0]   key_size;
    logic [255:0] key;
    logic         rk_valid, busy, done, err;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;

    logic         start2, rk_ready2;
    logic [1:0]   key_size2;
    logic         rk_valid2, busy2, done2, err2;
    logic [127:0] rk_data2;
    logic [3:0]   rk_index2;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, got_n = 0, done_cnt = 0, err_cnt = 0, exp_nr = 10;
    int s_cyc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
    bit rnd_mode = 1'b0, prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    logic [127:0] got [0:15];

    aes_key_schedule_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .key_size(key_size), .key(key),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index),
        .busy(busy), .done(done), .err(err)
    );

    aes_key_schedule_engine #(.ENABLE_192(1), .ENABLE_256(0)) u_dut_no256 (
        .clk(clk), .rst(rst), .start(start2), .key_size(key_size2), .key(key),
        .rk_valid(rk_valid2), .rk_ready(rk_ready2), .rk_data(rk_data2), .rk_index(rk_index2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer model: samples 1 ns after each edge, drives rk_ready, logs accepted keys
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                rk_ready   = 1'b1;
            end else begin
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (err) err_cnt++;
                if (prev_stall) begin
                    chk_eq("stall_valid", 128'(rk_valid), 128'(1));
                    chk_eq("stall_data", rk_data, prev_data);
                    chk_eq("stall_index", 128'(rk_index), 128'(prev_idx));
                end
                rk_ready = rnd_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
                if (rk_valid && first_cyc < 0) first_cyc = cyc;
                if (rk_valid && rk_index == 4'(exp_nr) && last_cyc < 0) last_cyc = cyc;
                if (rk_valid && rk_ready) begin
                    chk_eq("rk_index_seq", 128'(rk_index), 128'(got_n));
                    if (got_n < 16) got[got_n] = rk_data;
                    got_n++;
                end
                prev_stall = rk_valid && !rk_ready;
                prev_data  = rk_data;
                prev_idx   = rk_index;
            end
        end
    end

    task automatic expand(input logic [1:0] sz, input logic [255:0] k, input int nr,
                          input bit rnd, input bit inj);
        int e0;
        got_n = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        exp_nr = nr; rnd_mode = rnd; e0 = err_cnt;
        @(negedge clk);
        key_size = sz; key = k; start = 1'b1; s_cyc = cyc;
        @(negedge clk);
        start = 1'b0; key = ~k;
        for (int c = 0; c < 600 && done_cnt == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj && c == 8)  begin start = 1'b1; key_size = 2'b00; key = '1; end
            if (inj && c == 20) begin start = 1'b1; key_size = 2'b11; end
        end
        start = 1'b0;
        chk_eq("done_seen", 128'(done_cnt), 128'(1));
        repeat (3) @(negedge clk);
        chk_eq("done_width", 128'(done_cnt), 128'(1));
        chk_eq("key_count", 128'(got_n), 128'(nr + 1));
        chk_eq("busy_after", 128'(busy), 128'(0));
        chk_eq("valid_after", 128'(rk_valid), 128'(0));
        chk_eq("no_err", 128'(err_cnt), 128'(e0));
        chk_eq("r0", got[0], k[255:128]);
        rnd_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_size = 2'b00; key = '0;
        start2 = 1'b0; key_size2 = 2'b00; rk_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_valid", 128'(rk_valid), 128'(0));
        chk_eq("rst_busy", 128'(busy), 128'(0));
        chk_eq("rst_done", 128'(done), 128'(0));
        chk_eq("rst_err", 128'(err), 128'(0));
        chk_eq("rst_data", rk_data, 128'(0));
        chk_eq("rst_index", 128'(rk_index), 128'(0));
        rst = 1'b0;

        // AES-128, consumer always ready: check cadence and latency
        expand(2'b00, K128A, 10, 1'b0, 1'b0);
        chk_eq("a128_r1", got[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk_eq("a128_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk_eq("a128_first_lat", 128'(first_cyc - s_cyc), 128'(5));
        chk_eq("a128_last_lat", 128'(last_cyc - s_cyc), 128'(45));
        chk_eq("a128_done_lat", 128'(done_cyc - s_cyc), 128'(46));
        chk_eq("a128_last_data", rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk_eq("a128_last_index", 128'(rk_index), 128'(10));

        // AES-192 and AES-256
        expand(2'b01, K192, 12, 1'b0, 1'b0);
        chk_eq("a192_r12", got[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
        expand(2'b10, K256, 14, 1'b0, 1'b0);
        chk_eq("a256_r1", got[1], 128'h101112131415161718191a1b1c1d1e1f);
        chk_eq("a256_r14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // backpressure
        expand(2'b00, K2B, 10, 1'b1, 1'b0);
        chk_eq("bp_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk_eq("bp_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // illegal key size
        begin
            int e0;
            e0 = err_cnt;
            @(negedge clk); key_size = 2'b11; start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk_eq("ill_err_now", 128'(err), 128'(1));
            repeat (3) @(negedge clk);
            chk_eq("ill_err_pulse", 128'(err_cnt), 128'(e0 + 1));
            chk_eq("ill_busy", 128'(busy), 128'(0));
            chk_eq("ill_valid", 128'(rk_valid), 128'(0));
        end

        // instance without 256-bit support
        @(negedge clk); key = K128A; key_size2 = 2'b10; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk_eq("no256_err", 128'(err2), 128'(1));
        chk_eq("no256_busy", 128'(busy2), 128'(0));
        chk_eq("no256_valid", 128'(rk_valid2), 128'(0));
        @(negedge clk);
        chk_eq("no256_err_clr", 128'(err2), 128'(0));
        key_size2 = 2'b00; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk_eq("no256_128_busy", 128'(busy2), 128'(1));
        for (int c = 0; c < 100 && !done2; c++) @(negedge clk);
        chk_eq("no256_done", 128'(done2), 128'(1));
        chk_eq("no256_r10", rk_data2, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk_eq("no256_idx", 128'(rk_index2), 128'(10));

        // starts while busy must be ignored
        expand(2'b00, K128A, 10, 1'b0, 1'b1);
        chk_eq("inj_r1", got[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk_eq("inj_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // asynchronous reset mid-expansion
        got_n = 0; done_cnt = 0; exp_nr = 10;
        @(negedge clk); key_size = 2'b00; key = K2B; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100 && !(rk_valid && rk_index == 4'd5); c++) @(negedge clk);
        chk_eq("mid_r5_reached", 128'(rk_index), 128'(5));
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_valid", 128'(rk_valid), 128'(0));
        chk_eq("mid_rst_busy", 128'(busy), 128'(0));
        chk_eq("mid_rst_data", rk_data, 128'(0));
        chk_eq("mid_rst_index", 128'(rk_index), 128'(0));
        chk_eq("mid_rst_done", 128'(done), 128'(0));
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_eq("mid_no_done", 128'(done_cnt), 128'(0));
        chk_eq("mid_idle", 128'(busy), 128'(0));
        expand(2'b00, K2B, 10, 1'b0, 1'b0);
        chk_eq("post_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk_eq("post_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
